serial_comparator: RTL

Bit-serial magnitude comparator feeding the branch-condition decoder. It compares two operand words MSB-first, one bit per clock, and stops at the first differing bit. It then drives the one-hot less-than / equal / greater-than flags the decoder converts into blt/bgt/beq/ble/bge/bne. A start/done handshake lets the control FSM launch a compare and wait for a result, trading latency for area against a parallel comparator.

---
 rtl/serial_comparator_if.sv | 27 ++
 rtl/serial_comparator.sv | 101 ++++++++++
 2 files changed

// File: rtl/serial_comparator_if.sv
// Handshake and operand bundle for the bit-serial magnitude comparator.
//   start, is_signed, a, b : request side, driven by the control FSM (master)
//   busy, done             : status, driven by the comparator (slave)
//   aLessThanB / aEqualB / aGreaterThanB : one-hot result flags
interface serial_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             aLessThanB;
  logic             aEqualB;
  logic             aGreaterThanB;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, aLessThanB, aEqualB, aGreaterThanB
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, aLessThanB, aEqualB, aGreaterThanB
  );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator. Operands are latched on an accepted start
// and scanned MSB-first, one bit per clock, stopping at the first differing
// bit. The result is registered as one-hot LT/EQ/GT flags with a one-cycle
// done pulse; the flags hold until the next result is registered.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_comparator_if.slave (start/is_signed/a/b in,
//           busy/done/flags out, all outputs registered)
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_comparator_if.slave    bus
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;

  logic w_a_bit;
  logic w_b_bit;
  logic w_sign_flip;
  logic w_gt;

  // At the sign position of a signed compare a set bit means "more negative",
  // so the sense of the decision is inverted there.
  assign w_a_bit     = r_a[r_idx];
  assign w_b_bit     = r_b[r_idx];
  assign w_sign_flip = r_signed & (r_idx == MSB_IDX);
  assign w_gt        = w_a_bit ^ w_sign_flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_signed <= bus.is_signed;
            r_idx    <= MSB_IDX;
            r_busy   <= 1'b1;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          if (w_a_bit != w_b_bit) begin
            r_lt    <= ~w_gt;
            r_eq    <= 1'b0;
            r_gt    <= w_gt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_idx == '0) begin
            r_lt    <= 1'b0;
            r_eq    <= 1'b1;
            r_gt    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.aLessThanB    = r_lt;
  assign bus.aEqualB       = r_eq;
  assign bus.aGreaterThanB = r_gt;

endmodule
